lcd_bus_decoder: RTL and testbench

- Receiving end of the 8-bit parallel LCD write bus (wr, dcx, D) driven by image_generator.
- Decodes the byte stream into display commands, address windows and RGB565 pixel writes with (x,y) coordinates.
- Serves as a bus checker in simulation and as an FPGA-side display mirror.
- Output is a pixel-write stream plus display status flags.

---
 rtl/lcd_bus_if.sv | 30 +++
 rtl/lcd_bus_decoder.sv | 186 ++++++++++++++++++
 tb/tb_lcd_bus_decoder.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/lcd_bus_if.sv
// LCD 8-bit parallel write bus (wr/dcx/D) plus the decoded pixel/status outputs.
// The master drives the byte bus; the slave returns pixels and status.
interface lcd_bus_if #(
    parameter int COORD_W = 9
);
    logic               wr;
    logic               dcx;
    logic [7:0]         D;
    logic               pix_valid;
    logic [COORD_W-1:0] pix_x;
    logic [COORD_W-1:0] pix_y;
    logic [15:0]        pix_rgb;
    logic               cmd_strobe;
    logic [7:0]         last_cmd;
    logic               disp_on;
    logic               awake;
    logic               proto_err;

    modport master (
        output wr, dcx, D,
        input  pix_valid, pix_x, pix_y, pix_rgb, cmd_strobe, last_cmd,
               disp_on, awake, proto_err
    );

    modport slave (
        input  wr, dcx, D,
        output pix_valid, pix_x, pix_y, pix_rgb, cmd_strobe, last_cmd,
               disp_on, awake, proto_err
    );
endinterface

// File: rtl/lcd_bus_decoder.sv
// Receiving end of the LCD write bus: decodes commands, CASET/PASET windows
// and RGB565 RAMWR pixels into a registered pixel stream with (x,y).
module lcd_bus_decoder #(
    parameter int COORD_W  = 9,
    parameter int MAX_COL  = 239,
    parameter int MAX_PAGE = 319
) (
    input  logic        clk,
    input  logic        nrst,
    lcd_bus_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, CASET, PASET, RAMWR, SKIP} state_t;

    localparam logic [COORD_W-1:0] EC_RST = COORD_W'(MAX_COL);
    localparam logic [COORD_W-1:0] EP_RST = COORD_W'(MAX_PAGE);

    state_t             state_q, state_d;
    logic               wr_q;
    logic [2:0]         pidx_q, pidx_d;
    logic [7:0]         hi_q, hi_d;
    logic               half_q, half_d;
    logic [COORD_W-1:0] sc_q, sc_d, ec_q, ec_d, sp_q, sp_d, ep_q, ep_d;
    logic [COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
    logic               pix_valid_q, pix_valid_d;
    logic [COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [15:0]        pix_rgb_q, pix_rgb_d;
    logic               cmd_strobe_q, cmd_strobe_d;
    logic [7:0]         last_cmd_q, last_cmd_d;
    logic               disp_on_q, disp_on_d;
    logic               awake_q, awake_d;
    logic               err_q, err_d;

    logic               stb;
    logic [15:0]        par16;
    logic [COORD_W-1:0] par;

    assign stb   = bus.wr & ~wr_q;
    assign par16 = {hi_q, bus.D};
    assign par   = par16[COORD_W-1:0];

    always_comb begin
        state_d      = state_q;
        pidx_d       = pidx_q;
        hi_d         = hi_q;
        half_d       = half_q;
        sc_d         = sc_q;
        ec_d         = ec_q;
        sp_d         = sp_q;
        ep_d         = ep_q;
        cx_d         = cx_q;
        cy_d         = cy_q;
        pix_valid_d  = 1'b0;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_rgb_d    = pix_rgb_q;
        cmd_strobe_d = 1'b0;
        last_cmd_d   = last_cmd_q;
        disp_on_d    = disp_on_q;
        awake_d      = awake_q;
        err_d        = err_q;

        if (stb && !bus.dcx) begin
            cmd_strobe_d = 1'b1;
            last_cmd_d   = bus.D;
            pidx_d       = '0;
            half_d       = 1'b0;
            // A command while half a pixel is buffered drops that byte.
            if (state_q == RAMWR && half_q) err_d = 1'b1;
            case (bus.D)
                8'h2A: state_d = CASET;
                8'h2B: state_d = PASET;
                8'h2C: begin
                    state_d = RAMWR;
                    cx_d    = sc_q;
                    cy_d    = sp_q;
                end
                8'h01: begin
                    state_d   = IDLE;
                    sc_d      = '0;
                    ec_d      = EC_RST;
                    sp_d      = '0;
                    ep_d      = EP_RST;
                    cx_d      = '0;
                    cy_d      = '0;
                    disp_on_d = 1'b0;
                    awake_d   = 1'b0;
                end
                8'h11: begin state_d = IDLE; awake_d   = 1'b1; end
                8'h10: begin state_d = IDLE; awake_d   = 1'b0; end
                8'h29: begin state_d = IDLE; disp_on_d = 1'b1; end
                8'h28: begin state_d = IDLE; disp_on_d = 1'b0; end
                default: state_d = SKIP;
            endcase
        end else if (stb) begin
            case (state_q)
                IDLE: err_d = 1'b1;
                CASET, PASET: begin
                    // Index saturates at 4: extra parameters are ignored.
                    if (!pidx_q[2]) begin
                        pidx_d = pidx_q + 3'd1;
                        case (pidx_q[1:0])
                            2'd1: if (state_q == CASET) sc_d = par; else sp_d = par;
                            2'd3: if (state_q == CASET) ec_d = par; else ep_d = par;
                            default: hi_d = bus.D;
                        endcase
                    end
                end
                RAMWR: begin
                    if (!half_q) begin
                        hi_d   = bus.D;
                        half_d = 1'b1;
                    end else begin
                        half_d      = 1'b0;
                        pix_valid_d = 1'b1;
                        pix_rgb_d   = {hi_q, bus.D};
                        pix_x_d     = cx_q;
                        pix_y_d     = cy_q;
                        if (cx_q >= ec_q) begin
                            cx_d = sc_q;
                            cy_d = (cy_q >= ep_q) ? sp_q : cy_q + 1'b1;
                        end else begin
                            cx_d = cx_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= IDLE;
            wr_q         <= 1'b1;
            pidx_q       <= '0;
            hi_q         <= '0;
            half_q       <= 1'b0;
            sc_q         <= '0;
            ec_q         <= EC_RST;
            sp_q         <= '0;
            ep_q         <= EP_RST;
            cx_q         <= '0;
            cy_q         <= '0;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_rgb_q    <= '0;
            cmd_strobe_q <= 1'b0;
            last_cmd_q   <= '0;
            disp_on_q    <= 1'b0;
            awake_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_q         <= bus.wr;
            pidx_q       <= pidx_d;
            hi_q         <= hi_d;
            half_q       <= half_d;
            sc_q         <= sc_d;
            ec_q         <= ec_d;
            sp_q         <= sp_d;
            ep_q         <= ep_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            pix_valid_q  <= pix_valid_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_rgb_q    <= pix_rgb_d;
            cmd_strobe_q <= cmd_strobe_d;
            last_cmd_q   <= last_cmd_d;
            disp_on_q    <= disp_on_d;
            awake_q      <= awake_d;
            err_q        <= err_d;
        end
    end

    assign bus.pix_valid  = pix_valid_q;
    assign bus.pix_x      = pix_x_q;
    assign bus.pix_y      = pix_y_q;
    assign bus.pix_rgb    = pix_rgb_q;
    assign bus.cmd_strobe = cmd_strobe_q;
    assign bus.last_cmd   = last_cmd_q;
    assign bus.disp_on    = disp_on_q;
    assign bus.awake      = awake_q;
    assign bus.proto_err  = err_q;
endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Directed bench for lcd_bus_decoder: windowed pixel writes, wrap, abort,
// protocol errors, soft and async reset.
module tb_lcd_bus_decoder;
    logic clk;
    logic nrst;

    lcd_bus_if #(.COORD_W(9)) bus();

    lcd_bus_decoder #(.COORD_W(9), .MAX_COL(239), .MAX_PAGE(319)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // Pixels packed as {x[8:0], y[8:0], rgb[15:0]}
    logic [33:0] pq[$];
    int          ncmd = 0;

    always @(negedge clk) begin
        if (bus.pix_valid) pq.push_back({bus.pix_x, bus.pix_y, bus.pix_rgb});
        if (bus.cmd_strobe) ncmd++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called just after a posedge; strobe accepted at the next edge, then wr low one cycle.
    task automatic send(input logic c, input logic [7:0] d);
        bus.dcx = c;
        bus.D   = d;
        bus.wr  = 1'b1;
        @(posedge clk); #1;
        bus.wr  = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        #3;
        nrst = 1'b1;
        @(posedge clk); #1;
    endtask

    function automatic logic [33:0] px(input int x, input int y, input logic [15:0] rgb);
        logic [8:0] xx, yy;
        xx = 9'(x);
        yy = 9'(y);
        return {xx, yy, rgb};
    endfunction

    task automatic chk_pix(input string tag, input logic [33:0] exp);
        if (pq.size() == 0) chk(tag, 64'hDEAD, {30'd0, exp});
        else chk(tag, {30'd0, pq.pop_front()}, {30'd0, exp});
    endtask

    int c0;

    initial begin
        bus.wr = 1'b0; bus.dcx = 1'b0; bus.D = 8'h00;
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1 nrst = 1'b1;
        @(posedge clk); #1;

        // Reset state
        chk("rst_pix_valid", bus.pix_valid, 0);
        chk("rst_cmd_strobe", bus.cmd_strobe, 0);
        chk("rst_status", {bus.disp_on, bus.awake, bus.proto_err, bus.last_cmd}, 0);
        chk("rst_pix", {bus.pix_x, bus.pix_y, bus.pix_rgb}, 0);

        // Data in IDLE
        send(1, 8'h55);
        chk("idle_err", bus.proto_err, 1);
        chk("idle_other", {bus.disp_on, bus.awake, bus.last_cmd, 9'(pq.size()), 8'(ncmd)}, 0);
        do_reset();
        chk("reset_clears_err", bus.proto_err, 0);

        // Window write
        send(0, 8'h2A); send(1, 8'h00); send(1, 8'h05); send(1, 8'h00); send(1, 8'h06);
        send(0, 8'h2B); send(1, 8'h00); send(1, 8'h0A); send(1, 8'h00); send(1, 8'h0B);
        send(0, 8'h2C);
        send(1, 8'hF8); send(1, 8'h00); send(1, 8'h07); send(1, 8'hE0);
        send(1, 8'h00); send(1, 8'h1F); send(1, 8'hFF); send(1, 8'hFF);
        chk("win_count", pq.size(), 4);
        chk_pix("win_p0", px(5, 10, 16'hF800));
        chk_pix("win_p1", px(6, 10, 16'h07E0));
        chk_pix("win_p2", px(5, 11, 16'h001F));
        chk_pix("win_p3", px(6, 11, 16'hFFFF));
        chk("win_held_rgb", bus.pix_rgb, 16'hFFFF);

        // Full wrap
        send(1, 8'h11); send(1, 8'h22); send(1, 8'h33); send(1, 8'h44);
        chk_pix("wrap_p0", px(5, 10, 16'h1122));
        chk_pix("wrap_p1", px(6, 10, 16'h3344));
        chk("wrap_err", {bus.proto_err, bus.last_cmd}, {1'b0, 8'h2C});

        // Abort with dangling half pixel
        c0 = ncmd;
        send(1, 8'hAA);
        send(0, 8'h29);
        chk("abort_nopix", pq.size(), 0);
        chk("abort_flags", {bus.proto_err, bus.disp_on, bus.last_cmd}, {1'b1, 1'b1, 8'h29});
        chk("abort_one_cmd", ncmd - c0, 1);

        // Unknown command then RAMWR at default window
        do_reset();
        send(0, 8'h36); send(1, 8'h48);
        send(0, 8'h2C); send(1, 8'h12); send(1, 8'h34);
        chk("unk_err", bus.proto_err, 0);
        chk_pix("unk_p0", px(0, 0, 16'h1234));

        // Soft reset after window change
        send(0, 8'h2A); send(1, 8'h00); send(1, 8'h03); send(1, 8'h00); send(1, 8'h04);
        send(0, 8'h29); send(0, 8'h11);
        chk("on_awake", {bus.disp_on, bus.awake}, 2'b11);
        send(0, 8'h01);
        chk("swrst_flags", {bus.disp_on, bus.awake, bus.last_cmd}, {2'b00, 8'h01});
        send(0, 8'h2C); send(1, 8'hAB); send(1, 8'hCD);
        chk_pix("swrst_p0", px(0, 0, 16'hABCD));

        // Inverted window: single column SC
        send(0, 8'h2A); send(1, 8'h00); send(1, 8'h08); send(1, 8'h00); send(1, 8'h02);
        send(1, 8'h01); // extra parameter ignored
        send(0, 8'h2B); send(1, 8'h00); send(1, 8'h00); send(1, 8'h00); send(1, 8'h01);
        send(0, 8'h2C);
        send(1, 8'h00); send(1, 8'h01); send(1, 8'h00); send(1, 8'h02); send(1, 8'h00); send(1, 8'h03);
        chk_pix("inv_p0", px(8, 0, 16'h0001));
        chk_pix("inv_p1", px(8, 1, 16'h0002));
        chk_pix("inv_p2", px(8, 0, 16'h0003));
        chk("inv_err", bus.proto_err, 0);

        // Async reset between hi and lo bytes
        send(0, 8'h2C);
        send(1, 8'h5A);
        do_reset();
        chk("arst_state", {bus.proto_err, bus.pix_valid, bus.last_cmd, bus.pix_rgb}, 0);
        send(1, 8'hA5);
        chk("arst_nopix", pq.size(), 0);
        chk("arst_idle_err", bus.proto_err, 1);

        // wr held high through reset must not strobe
        c0 = ncmd;
        bus.dcx = 1'b0; bus.D = 8'h29; bus.wr = 1'b1;
        nrst = 1'b0; #3; nrst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        bus.wr = 1'b0;
        @(posedge clk); #1;
        chk("wr_high_rst", {8'(ncmd - c0), bus.disp_on, bus.last_cmd}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
